instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Bus initiator that fetches 32-bit instructions from the instruction ROM (select 4'h1) over the shared
//  address/nRead/data bus, one word per fetch. Splits each word into opcode::dest::src1::src2 (8b each) and
//  offers it to the execute engine via valid/ready. Stops on opcode FFh; supports PC redirect from execute.
// PARAMETERS
//  MEM_SEL    4'h1  value driven on address[15:12] during a fetch
//  PC_W       12    program counter width (= address[11:0])
//  MEM_DEPTH  15    number of ROM words; fetch at pc==MEM_DEPTH is an overrun
// PORTS
//  Clk         in   1   bus clock; FSM on posedge
//  nReset      in   1   reset nReset, asynchronous, active-low
//  start       in   1   pulse: begin fetching at pc 0 (accepted in IDLE/HALT only)
//  bus_req     out  1   request for shared address bus
//  bus_gnt     in   1   bus granted; address/nRead only valid while granted
//  address     out  16  {MEM_SEL, pc} while granted, else 16'h0000
//  nRead       out  1   active-low read strobe to ROM
//  data_in     in   32  shared data bus (ROM drive)
//  instr_valid out  1   decoded instruction held on outputs
//  instr_ready in   1   execute accepts instruction (handshake when valid&ready)
//  opcode/dest/src1/src2 out 8 each  fields [31:24]/[23:16]/[15:8]/[7:0] of fetched word
//  instr_pc    out  12  pc of presented instruction
//  branch_en   in   1   redirect fetch to branch_pc
//  branch_pc   in   12  redirect target
//  halted      out  1   FFh fetched or overrun; sticky until start/reset
//  overrun     out  1   halt caused by pc reaching MEM_DEPTH
// BEHAVIOUR
//  Reset: all outputs 0 except nRead=1; pc=0; state IDLE. Reset mid-fetch aborts immediately, no bus activity.
//  States: IDLE, ARB, REQ, CAPT, VALID, HALT.
//   IDLE: start -> ARB, pc=0, clear halted/overrun.
//   ARB: bus_req=1; bus_gnt -> REQ. If pc==MEM_DEPTH -> HALT, overrun=1, no bus cycle.
//   REQ: address={MEM_SEL,pc}, nRead=0 for one full cycle (ROM latches on the negedge inside it) -> CAPT.
//   CAPT: address held, nRead=1; data_in sampled at this posedge+1 into instr reg; bus_req drops next cycle.
//     opcode FFh -> HALT (not presented). Otherwise -> VALID, instr_valid=1, instr_pc=pc, pc=pc+1.
//   VALID: outputs stable until valid&ready; then -> ARB (back-to-back, no idle cycle).
//   HALT: halted=1, bus_req=0; start -> ARB with pc=0.
//  Latency: grant to instr_valid = 3 cycles (REQ, CAPT, register). Throughput = 1 instr / 4 cycles when ready held.
//  bus_gnt deasserted in REQ/CAPT: abort, nRead=1, return to ARB, same pc refetched.
//  branch_en (any state except IDLE/HALT) has priority over everything: pc=branch_pc, instr_valid=0 next cycle,
//   in-flight fetch discarded (nRead released), -> ARB. branch_en with valid&ready same cycle: handshake counts
//   as consumed, redirect still taken.
//  pc is PC_W wide; pc+1 never wraps in practice since overrun check triggers at MEM_DEPTH.
//  start outside IDLE/HALT ignored.
// CONFIGURATION
//  IFETCH_ILLEGAL_OP_EN defined: opcodes outside {00-07,10-13,20-22,FF} -> HALT, extra output illegal_op=1
//   (sticky like halted), instruction not presented. Undefined: no illegal_op port; any non-FF opcode presented.
// STRUCTURE
//  Package ifetch_pkg: opcode_e enum (MMULT1..MSCALEIMM, INTADD..INTDIV, BR*, STOP=8'hFF), instr_t packed struct
//   {opcode,dest,src1,src2}, MEM_SEL constant, fetch_state_e.
//  Sub-module ifetch_decode: combinational 32b -> instr_t, is_stop, is_legal (legality only under the macro).
// TESTING
//  ROM model with 13 words ending FF_00_00_00, bus_gnt=1, ready=1, start: 12 instrs in order, first
//   03_02_00_01 at instr_pc 0, then halted=1, bus_req=0.
//  ready held 0 for 5 cycles on first instr: outputs stable, no new nRead pulse; release -> pc 1 fetched.
//  branch_en with branch_pc=6 during CAPT of pc 2: pc2 data discarded, next presented word at instr_pc 6.
//  ROM with no FF in 15 words: after instr_pc 14 accepted, overrun=1, halted=1, address stays 0.
//  bus_gnt dropped in REQ: nRead back to 1, refetch same pc after regrant, no duplicate presentation.
//  nReset low while VALID: instr_valid=0, nRead=1, bus_req=0 same cycle; IFETCH_ILLEGAL_OP_EN + opcode 0x30 -> illegal_op=1.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional build macro IFETCH_ILLEGAL_OP_EN enables the opcode legality check.
package ifetch_pkg;

    localparam logic [3:0] MEM_SEL   = 4'h1;
    localparam int         PC_W      = 12;
    localparam int         MEM_DEPTH = 15;

    // A fetch from this pc would read past the end of the ROM.
    localparam logic [PC_W-1:0] OVERRUN_PC = PC_W'(MEM_DEPTH);

    typedef enum logic [7:0] {
        MMULT1     = 8'h00,
        MMULT2     = 8'h01,
        MMULT3     = 8'h02,
        MADD       = 8'h03,
        MSUB       = 8'h04,
        MTRANSPOSE = 8'h05,
        MSCALE     = 8'h06,
        MSCALEIMM  = 8'h07,
        INTADD     = 8'h10,
        INTSUB     = 8'h11,
        INTMUL     = 8'h12,
        INTDIV     = 8'h13,
        BREQ       = 8'h20,
        BRNE       = 8'h21,
        BRLT       = 8'h22,
        STOP       = 8'hFF
    } opcode_e;

    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] dest;
        logic [7:0] src1;
        logic [7:0] src2;
    } instr_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARB   = 3'd1,
        REQ   = 3'd2,
        CAPT  = 3'd3,
        VALID = 3'd4,
        HALT  = 3'd5
    } fetch_state_e;

    function automatic logic isLegalOpcode(input logic [7:0] op);
        return (op inside {[8'h00:8'h07], [8'h10:8'h13], [8'h20:8'h22], 8'hFF});
    endfunction

endpackage

// File: rtl/ifetch_decode.sv
// Combinational split of a fetched ROM word into instruction fields plus stop/legality flags.
// With IFETCH_ILLEGAL_OP_EN undefined every opcode is reported legal.
module ifetch_decode
    import ifetch_pkg::*;
(
    input  logic [31:0] word,
    output instr_t      instr,
    output logic        isStop,
    output logic        isLegal
);

    assign instr  = instr_t'(word);
    assign isStop = (word[31:24] == STOP);

`ifdef IFETCH_ILLEGAL_OP_EN
    assign isLegal = isLegalOpcode(word[31:24]);
`else
    assign isLegal = 1'b1;
`endif

endmodule

// File: rtl/instr_fetch_unit.sv
// Bus initiator fetching one 32-bit ROM word per bus cycle and presenting it via valid/ready.
// Build macro IFETCH_ILLEGAL_OP_EN adds the illegal_op output and halts on undefined opcodes.
module instr_fetch_unit
    import ifetch_pkg::*;
(
    input  logic            Clk,
    input  logic            nReset,
    input  logic            start,
    output logic            bus_req,
    input  logic            bus_gnt,
    output logic [15:0]     address,
    output logic            nRead,
    input  logic [31:0]     data_in,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [7:0]      opcode,
    output logic [7:0]      dest,
    output logic [7:0]      src1,
    output logic [7:0]      src2,
    output logic [PC_W-1:0] instr_pc,
    input  logic            branch_en,
    input  logic [PC_W-1:0] branch_pc,
    output logic            halted,
    output logic            overrun,
`ifdef IFETCH_ILLEGAL_OP_EN
    output logic            illegal_op,
`endif
    output logic [2:0]      dbgState
);

    // Handshake: an instruction transfers on any posedge where instr_valid and
    // instr_ready are both high; while instr_valid is high and instr_ready low,
    // opcode/dest/src1/src2/instr_pc hold their values unchanged.

    fetch_state_e    state, stateNext;
    logic [PC_W-1:0] pc, pcNext;
    instr_t          instrReg;
    logic [PC_W-1:0] instrPcReg;
    logic            overrunReg;

    instr_t decInstr;
    logic   decStop;
    logic   decLegal;

    logic loadInstr;
    logic clearFlags;
    logic setOverrun;
    logic fetchActive;

`ifdef IFETCH_ILLEGAL_OP_EN
    logic illegalReg;
    logic setIllegal;
`endif

    ifetch_decode uDecode (
        .word    (data_in),
        .instr   (decInstr),
        .isStop  (decStop),
        .isLegal (decLegal)
    );

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state      <= IDLE;
            pc         <= '0;
            instrReg   <= '0;
            instrPcReg <= '0;
            overrunReg <= 1'b0;
        end else begin
            state <= stateNext;
            pc    <= pcNext;
            if (loadInstr) begin
                instrReg   <= decInstr;
                instrPcReg <= pc;
            end
            if (clearFlags) begin
                overrunReg <= 1'b0;
            end else if (setOverrun) begin
                overrunReg <= 1'b1;
            end
        end
    end

`ifdef IFETCH_ILLEGAL_OP_EN
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            illegalReg <= 1'b0;
        end else if (clearFlags) begin
            illegalReg <= 1'b0;
        end else if (setIllegal) begin
            illegalReg <= 1'b1;
        end
    end
`endif

    always_comb begin
        stateNext  = state;
        pcNext     = pc;
        loadInstr  = 1'b0;
        clearFlags = 1'b0;
        setOverrun = 1'b0;
`ifdef IFETCH_ILLEGAL_OP_EN
        setIllegal = 1'b0;
`endif
        // A redirect overrides everything else while fetching, including the
        // overrun check and a completing capture.
        if (branch_en && (state != IDLE) && (state != HALT)) begin
            stateNext = ARB;
            pcNext    = branch_pc;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        stateNext  = ARB;
                        pcNext     = '0;
                        clearFlags = 1'b1;
                    end
                end
                ARB: begin
                    if (pc == OVERRUN_PC) begin
                        stateNext  = HALT;
                        setOverrun = 1'b1;
                    end else if (bus_gnt) begin
                        stateNext = REQ;
                    end
                end
                REQ: begin
                    stateNext = bus_gnt ? CAPT : ARB;
                end
                CAPT: begin
                    if (!bus_gnt) begin
                        stateNext = ARB;
                    end else if (decStop) begin
                        stateNext = HALT;
                    end else if (!decLegal) begin
                        stateNext = HALT;
`ifdef IFETCH_ILLEGAL_OP_EN
                        setIllegal = 1'b1;
`endif
                    end else begin
                        stateNext = VALID;
                        loadInstr = 1'b1;
                        pcNext    = pc + PC_W'(1);
                    end
                end
                VALID: begin
                    if (instr_ready) begin
                        stateNext = ARB;
                    end
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
        end
    end

    // Bus signals are decoded straight from state so an asynchronous reset
    // or a lost grant releases the bus in the same cycle.
    assign fetchActive = ((state == REQ) || (state == CAPT)) && bus_gnt;
    assign bus_req     = (state == ARB) || (state == REQ) || (state == CAPT);
    assign address     = fetchActive ? {MEM_SEL, pc} : 16'h0000;
    assign nRead       = !((state == REQ) && bus_gnt);

    assign instr_valid = (state == VALID);
    assign halted      = (state == HALT);
    assign overrun     = overrunReg;
    assign opcode      = instrReg.opcode;
    assign dest        = instrReg.dest;
    assign src1        = instrReg.src1;
    assign src2        = instrReg.src2;
    assign instr_pc    = instrPcReg;
    assign dbgState    = state;

`ifdef IFETCH_ILLEGAL_OP_EN
    assign illegal_op  = illegalReg;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit against a ROM model and a program-walk reference.
// Covers reset, ready stalls, redirects, grant loss, overrun and (with IFETCH_ILLEGAL_OP_EN) illegal opcodes.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    logic        Clk;
    logic        nReset;
    logic        start;
    logic        bus_req;
    logic        bus_gnt;
    logic [15:0] address;
    logic        nRead;
    logic [31:0] data_in;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  opcode, dest, src1, src2;
    logic [11:0] instr_pc;
    logic        branch_en;
    logic [11:0] branch_pc;
    logic        halted;
    logic        overrun;
    logic [2:0]  dbgState;
`ifdef IFETCH_ILLEGAL_OP_EN
    logic        illegal_op;
`endif

    instr_fetch_unit dut (
        .Clk         (Clk),
        .nReset      (nReset),
        .start       (start),
        .bus_req     (bus_req),
        .bus_gnt     (bus_gnt),
        .address     (address),
        .nRead       (nRead),
        .data_in     (data_in),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .dest        (dest),
        .src1        (src1),
        .src2        (src2),
        .instr_pc    (instr_pc),
        .branch_en   (branch_en),
        .branch_pc   (branch_pc),
        .halted      (halted),
        .overrun     (overrun),
`ifdef IFETCH_ILLEGAL_OP_EN
        .illegal_op  (illegal_op),
`endif
        .dbgState    (dbgState)
    );

    // ---------------- clock / reset ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int cycleCnt = 0;
    always @(posedge Clk) cycleCnt <= cycleCnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- ROM model ----------------
    logic [31:0] rom [0:14];
    logic [31:0] romData = '0;
    always @(negedge Clk) begin
        if (!nRead && address[15:12] == 4'h1 && address[11:0] < 12'd15)
            romData <= rom[address[3:0]];
    end
    assign data_in = romData;

    logic [7:0] legalOps [0:14] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                                    8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22};

    function automatic logic [31:0] randLegalWord();
        logic [23:0] operands;
        operands = 24'($urandom);
        return {legalOps[$urandom_range(0, 14)], operands};
    endfunction

    function automatic logic legalOp(input logic [7:0] op);
        return (op <= 8'h07) || (op >= 8'h10 && op <= 8'h13) ||
               (op >= 8'h20 && op <= 8'h22) || (op == 8'hFF);
    endfunction

    // ---------------- scoreboard ----------------
    logic [43:0] exp_q[$];
    logic        expOverrun;
    logic        expIllegal;
    int          vecCount  = 0;
    int          missCount = 0;
    int          hsAt [0:15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference program walk: from a pc, the presented sequence runs until a
    // stop word, an illegal opcode (when checked) or the end of the ROM.
    task automatic buildQueue(input int fromPc);
        int p;
        p = fromPc;
        exp_q.delete();
        expOverrun = 1'b0;
        expIllegal = 1'b0;
        while (1) begin
            if (p >= 15) begin
                expOverrun = 1'b1;
                break;
            end
            if (rom[p][31:24] == 8'hFF) break;
`ifdef IFETCH_ILLEGAL_OP_EN
            if (!legalOp(rom[p][31:24])) begin
                expIllegal = 1'b1;
                break;
            end
`endif
            exp_q.push_back({p[11:0], rom[p]});
            p++;
        end
    endtask

    // Monitor: every accepted instruction is popped and compared.
    always @(negedge Clk) begin
        logic [43:0] expItem;
        if (nReset && instr_valid && instr_ready) begin
            hsAt[instr_pc[3:0]] = cycleCnt;
            if (exp_q.size() == 0) begin
                check("present_extra", {20'h0, instr_pc, opcode, dest, src1, src2}, 64'h0);
            end else begin
                expItem = exp_q.pop_front();
                check("present", {20'h0, instr_pc, opcode, dest, src1, src2}, {20'h0, expItem});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic pulseStart();
        buildQueue(0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic doBranch(input int target);
        branch_pc = target[11:0];
        branch_en = 1'b1;
        @(posedge Clk);
        buildQueue(target);
        #1;
        branch_en = 1'b0;
    endtask

    task automatic waitHalt(input int budget);
        for (int i = 0; i < budget && !halted; i++) tick(1);
    endtask

    task automatic waitValid(input string tag, input int budget);
        for (int i = 0; i < budget && !instr_valid; i++) tick(1);
        check({tag, "_valid_reached"}, instr_valid, 1);
    endtask

    task automatic waitFetch(input string tag, input logic [15:0] addr, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge Clk);
            seen = !nRead && (address == addr);
        end
        check({tag, "_fetch_seen"}, seen, 1);
    endtask

    task automatic finishCheck(input string tag);
        check({tag, "_halted"},  halted,  1);
        check({tag, "_overrun"}, overrun, expOverrun);
        check({tag, "_bus_idle"}, {bus_req, nRead, address}, {1'b0, 1'b1, 16'h0000});
        check({tag, "_queue_empty"}, exp_q.size(), 0);
`ifdef IFETCH_ILLEGAL_OP_EN
        check({tag, "_illegal_op"}, illegal_op, expIllegal);
`endif
    endtask

    task automatic loadProgramA();
        rom[0] = 32'h03020001;
        for (int i = 1; i < 12; i++) rom[i] = randLegalWord();
        rom[12] = 32'hFF000000;
        rom[13] = randLegalWord();
        rom[14] = randLegalWord();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        nReset      = 1'b0;
        start       = 1'b0;
        bus_gnt     = 1'b1;
        instr_ready = 1'b0;
        branch_en   = 1'b0;
        branch_pc   = '0;
        for (int i = 0; i < 16; i++) hsAt[i] = 0;

        #23;
        check("reset_bus", {bus_req, nRead, address}, {1'b0, 1'b1, 16'h0000});
        check("reset_status", {instr_valid, halted, overrun}, 3'b000);
        check("reset_instr", {instr_pc, opcode, dest, src1, src2}, 44'h0);
        @(posedge Clk); #1;
        nReset = 1'b1;
        tick(2);

        // Random: no stop word, random ready/grant and redirects, ends in overrun.
        for (int i = 0; i < 15; i++) rom[i] = randLegalWord();
        pulseStart();
        for (int c = 0; c < 3000 && !halted; c++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            bus_gnt     = ($urandom_range(0, 9) != 0);
            if (c < 400 && $urandom_range(0, 29) == 0) doBranch($urandom_range(0, 14));
            else tick(1);
        end
        bus_gnt     = 1'b1;
        instr_ready = 1'b1;
        waitHalt(200);
        finishCheck("rand");

        // Program ending in a stop word; stall on the first instruction.
        loadProgramA();
        instr_ready = 1'b0;
        pulseStart();
        waitValid("a", 20);
        repeat (5) begin
            @(negedge Clk);
            check("a_hold", {instr_valid, nRead, bus_req, instr_pc, opcode, dest, src1, src2},
                  {1'b1, 1'b1, 1'b0, 12'd0, 32'h03020001});
        end
        @(posedge Clk); #1;
        instr_ready = 1'b1;
        waitHalt(200);
        finishCheck("a");
        check("a_throughput", hsAt[5] - hsAt[4], 4);

        // Redirect to pc 6 while pc 2 is in its capture cycle.
        pulseStart();
        waitFetch("b", 16'h1002, 100);
        @(posedge Clk); #1;
        doBranch(6);
        check("b_redirect", {instr_valid, nRead, address}, {1'b0, 1'b1, 16'h0000});
        waitHalt(200);
        finishCheck("b");

        // Grant lost during the read cycle of pc 1.
        pulseStart();
        waitFetch("c", 16'h1001, 100);
        bus_gnt = 1'b0;
        #1;
        check("c_abort", {nRead, address}, {1'b1, 16'h0000});
        @(posedge Clk); #1;
        check("c_rearb", {bus_req, nRead}, 2'b11);
        tick(2);
        bus_gnt = 1'b1;
        waitHalt(200);
        finishCheck("c");

        // Asynchronous reset while an instruction is presented.
        instr_ready = 1'b0;
        pulseStart();
        waitValid("d", 20);
        #2;
        nReset = 1'b0;
        #1;
        check("d_reset", {instr_valid, nRead, bus_req, address, halted}, {1'b0, 1'b1, 1'b0, 16'h0000, 1'b0});
        exp_q.delete();
        #2;
        nReset = 1'b1;
        tick(2);
        check("d_idle", {instr_valid, bus_req}, 2'b00);

        // Undefined opcode at pc 3: presented in the default build, halts when checked.
        instr_ready = 1'b1;
        loadProgramA();
        rom[3] = 32'h30010203;
        pulseStart();
        waitHalt(200);
        finishCheck("f");

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
